// File: rtl/rr_mux_arbiter_if.sv
// Valid/ready stream with a packet delimiter.
// The arbiter uses the slave view on each requester and the master view toward the consumer.
interface rr_mux_arbiter_if #(
  parameter int DATA_W = 8
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/rr_mux_arbiter.sv
// Two-way round-robin packet arbiter feeding a registered 2:1 stream mux.
// The grant is held from the first beat of a packet through its last beat.
module rr_mux_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  rr_mux_arbiter_if.slave   in0,
  rr_mux_arbiter_if.slave   in1,
  rr_mux_arbiter_if.master  out,
  output logic              sel,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              ptr;
  logic              rdy0;
  logic              rdy1;
  logic              xfer0;
  logic              xfer1;
  logic              out_valid_r;
  logic              out_last_r;
  logic [DATA_W-1:0] out_data_r;

  assign xfer0 = in0.valid & rdy0;
  assign xfer1 = in1.valid & rdy1;

  // sel follows the granted requester and keeps its old value while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 1'b1;
      sel   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (xfer0 && in0.last) ptr <= 1'b0;
      else if (xfer1 && in1.last) ptr <= 1'b1;
      if (state_nxt == GRANT1) sel <= 1'b1;
      else if (state_nxt == GRANT0) sel <= 1'b0;
    end
  end

  // Re-arbitrate on the last-beat edge so back-to-back packets have no idle bubble
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in0.valid && in1.valid) state_nxt = ptr ? GRANT0 : GRANT1;
        else if (in0.valid)         state_nxt = GRANT0;
        else if (in1.valid)         state_nxt = GRANT1;
      end
      GRANT0: begin
        if (xfer0 && in0.last) begin
          if (in1.valid)      state_nxt = GRANT1;
          else if (in0.valid) state_nxt = GRANT0;
          else                state_nxt = IDLE;
        end
      end
      GRANT1: begin
        if (xfer1 && in1.last) begin
          if (in0.valid)      state_nxt = GRANT0;
          else if (in1.valid) state_nxt = GRANT1;
          else                state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Readies depend only on state and the output register, never on the requesters' valids
  always_comb begin
    rdy0 = 1'b0;
    rdy1 = 1'b0;
    busy = (state != IDLE);
    if (state == GRANT0) rdy0 = !out_valid_r || out.ready;
    if (state == GRANT1) rdy1 = !out_valid_r || out.ready;
  end

  assign in0.ready = rdy0;
  assign in1.ready = rdy1;

  // A new transfer reloads the register even while the old beat drains, for 1 beat/cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_last_r  <= 1'b0;
    end else if (xfer0 || xfer1) begin
      out_valid_r <= 1'b1;
      out_data_r  <= (state == GRANT1) ? in1.data : in0.data;
      out_last_r  <= (state == GRANT1) ? in1.last : in0.last;
    end else if (out.ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign out.valid = out_valid_r;
  assign out.data  = out_data_r;
  assign out.last  = out_last_r;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter; each step advances one clock and checks hand-computed values.
module tb_rr_mux_arbiter;

  logic clk;
  logic rst_n;
  logic sel;
  logic busy;
  int   vectors;
  int   miscompares;

  rr_mux_arbiter_if #(.DATA_W(8)) in0_if ();
  rr_mux_arbiter_if #(.DATA_W(8)) in1_if ();
  rr_mux_arbiter_if #(.DATA_W(8)) out_if ();

  rr_mux_arbiter #(.DATA_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .in0  (in0_if),
    .in1  (in1_if),
    .out  (out_if),
    .sel  (sel),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [7:0] d0, input logic l0,
                               input logic v1, input logic [7:0] d1, input logic l1,
                               input logic ordy);
    in0_if.valid = v0;
    in0_if.data  = d0;
    in0_if.last  = l0;
    in1_if.valid = v1;
    in1_if.data  = d1;
    in1_if.last  = l1;
    out_if.ready = ordy;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 1);
    step();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 1);

    // Reset values while held in reset
    checkOutput("rst_out_valid", 32'(out_if.valid), 32'd0);
    checkOutput("rst_out_data",  32'(out_if.data),  32'h00);
    checkOutput("rst_out_last",  32'(out_if.last),  32'd0);
    checkOutput("rst_sel",       32'(sel),          32'd0);
    checkOutput("rst_busy",      32'(busy),         32'd0);
    checkOutput("rst_in0_ready", 32'(in0_if.ready), 32'd0);
    checkOutput("rst_in1_ready", 32'(in1_if.ready), 32'd0);
    step();
    rst_n = 1'b1;
    #1;

    $display("[TB] single beat from in0");
    applyStimulus(1, 8'hA5, 1, 0, 8'h00, 0, 1);
    checkOutput("t1_idle_rdy0", 32'(in0_if.ready), 32'd0);
    step();
    checkOutput("t1_busy",      32'(busy),          32'd1);
    checkOutput("t1_sel",       32'(sel),           32'd0);
    checkOutput("t1_rdy0",      32'(in0_if.ready),  32'd1);
    checkOutput("t1_rdy1",      32'(in1_if.ready),  32'd0);
    checkOutput("t1_ov_early",  32'(out_if.valid),  32'd0);
    step();
    checkOutput("t1_ov",        32'(out_if.valid),  32'd1);
    checkOutput("t1_odata",     32'(out_if.data),   32'hA5);
    checkOutput("t1_olast",     32'(out_if.last),   32'd1);
    checkOutput("t1_sel2",      32'(sel),           32'd0);
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 1);
    step();
    checkOutput("t1_ov_drop",   32'(out_if.valid),  32'd0);

    $display("[TB] contested single-beat packets alternate");
    doReset();
    applyStimulus(1, 8'h11, 1, 1, 8'h22, 1, 1);
    step();
    checkOutput("t2_sel_first", 32'(sel),          32'd0);
    checkOutput("t2_rdy1_first", 32'(in1_if.ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput($sformatf("t2_ov_%0d", i),   32'(out_if.valid), 32'd1);
      checkOutput($sformatf("t2_data_%0d", i), 32'(out_if.data),  (i % 2 == 0) ? 32'h11 : 32'h22);
      checkOutput($sformatf("t2_sel_%0d", i),  32'(sel),          (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 1);
    step();
    checkOutput("t2_ov_drop", 32'(out_if.valid), 32'd0);

    $display("[TB] packet lock against a waiting in1");
    doReset();
    applyStimulus(1, 8'h01, 0, 1, 8'h33, 1, 1);
    step();
    checkOutput("t3_rdy1_a", 32'(in1_if.ready), 32'd0);
    step();
    checkOutput("t3_data1",  32'(out_if.data),  32'h01);
    checkOutput("t3_rdy1_b", 32'(in1_if.ready), 32'd0);
    applyStimulus(1, 8'h02, 0, 1, 8'h33, 1, 1);
    step();
    checkOutput("t3_data2",  32'(out_if.data),  32'h02);
    checkOutput("t3_rdy1_c", 32'(in1_if.ready), 32'd0);
    applyStimulus(1, 8'h03, 1, 1, 8'h33, 1, 1);
    step();
    checkOutput("t3_data3",  32'(out_if.data),  32'h03);
    checkOutput("t3_last3",  32'(out_if.last),  32'd1);
    checkOutput("t3_sel",    32'(sel),          32'd1);
    checkOutput("t3_rdy1_d", 32'(in1_if.ready), 32'd1);
    checkOutput("t3_rdy0",   32'(in0_if.ready), 32'd0);
    applyStimulus(0, 8'h00, 0, 1, 8'h33, 1, 1);
    step();
    checkOutput("t3_data_in1", 32'(out_if.data), 32'h33);
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 1);

    $display("[TB] backpressure mid-packet");
    doReset();
    applyStimulus(1, 8'h40, 0, 0, 8'h00, 0, 1);
    step();
    checkOutput("t4_rdy0_a", 32'(in0_if.ready), 32'd1);
    step();
    checkOutput("t4_data40", 32'(out_if.data),  32'h40);
    applyStimulus(1, 8'h41, 0, 0, 8'h00, 0, 0);
    checkOutput("t4_rdy0_full", 32'(in0_if.ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput($sformatf("t4_hold_data_%0d", i), 32'(out_if.data),  32'h40);
      checkOutput($sformatf("t4_hold_ov_%0d", i),   32'(out_if.valid), 32'd1);
      checkOutput($sformatf("t4_hold_rdy_%0d", i),  32'(in0_if.ready), 32'd0);
    end
    applyStimulus(1, 8'h41, 0, 0, 8'h00, 0, 1);
    checkOutput("t4_rdy0_resume", 32'(in0_if.ready), 32'd1);
    step();
    checkOutput("t4_data41", 32'(out_if.data), 32'h41);
    applyStimulus(1, 8'h42, 0, 0, 8'h00, 0, 1);
    step();
    checkOutput("t4_data42", 32'(out_if.data), 32'h42);
    applyStimulus(1, 8'h43, 1, 0, 8'h00, 0, 1);
    step();
    checkOutput("t4_data43", 32'(out_if.data), 32'h43);
    checkOutput("t4_last43", 32'(out_if.last), 32'd1);
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 1);
    step();
    checkOutput("t4_ov_drop", 32'(out_if.valid), 32'd0);

    $display("[TB] lone in1 after reset");
    doReset();
    applyStimulus(0, 8'h00, 0, 1, 8'h7E, 1, 1);
    step();
    checkOutput("t5_sel",  32'(sel),          32'd1);
    checkOutput("t5_rdy1", 32'(in1_if.ready), 32'd1);
    step();
    checkOutput("t5_data", 32'(out_if.data),  32'h7E);
    checkOutput("t5_ov",   32'(out_if.valid), 32'd1);
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 1);

    $display("[TB] reset in the middle of a packet");
    doReset();
    applyStimulus(0, 8'h00, 0, 1, 8'h91, 0, 1);
    step();
    checkOutput("t6_sel_pre", 32'(sel), 32'd1);
    step();
    checkOutput("t6_data91", 32'(out_if.data), 32'h91);
    checkOutput("t6_busy_pre", 32'(busy), 32'd1);
    applyStimulus(0, 8'h00, 0, 1, 8'h92, 0, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_ov_async",   32'(out_if.valid), 32'd0);
    checkOutput("t6_busy_async", 32'(busy),         32'd0);
    checkOutput("t6_sel_async",  32'(sel),          32'd0);
    checkOutput("t6_data_async", 32'(out_if.data),  32'h00);
    checkOutput("t6_rdy1_async", 32'(in1_if.ready), 32'd0);
    step();
    checkOutput("t6_busy_held", 32'(busy), 32'd0);
    rst_n = 1'b1;
    applyStimulus(1, 8'hA1, 1, 1, 8'hB1, 1, 1);
    step();
    checkOutput("t6_sel_tie",  32'(sel),          32'd0);
    checkOutput("t6_rdy0_tie", 32'(in0_if.ready), 32'd1);
    checkOutput("t6_rdy1_tie", 32'(in1_if.ready), 32'd0);
    step();
    checkOutput("t6_data_tie", 32'(out_if.data),  32'hA1);
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 1);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
